// File: rtl/axis_bram_line_packer.sv
// Packs WORDS_PER_LINE stream words into one BRAM line and writes lines over [start, bound].
// One write cycle per line (tready low there), so a line costs WORDS_PER_LINE+1 cycles.
module axis_bram_line_packer #(
    parameter int DATA_WIDTH       = 16,
    parameter int WORDS_PER_LINE   = 36,
    parameter int BRAM_ADDR_LENGTH = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [BRAM_ADDR_LENGTH-1:0]          bram_start_index,
    input  logic [BRAM_ADDR_LENGTH-1:0]          bram_bound_index,
    input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic                                 bram_en,
    output logic                                 bram_wen,
    output logic [BRAM_ADDR_LENGTH-1:0]          bram_index,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] bram_wdata,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 tlast_mismatch
);
    localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
    localparam int CNT_W  = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LINE_W-1:0]           buf_q, buf_d;
    logic [BRAM_ADDR_LENGTH-1:0] idx_q, idx_d;
    logic [BRAM_ADDR_LENGTH-1:0] bound_q, bound_d;
    logic                        tl_q, tl_d;
    logic                        err_q, err_d;
    logic                        en_q, en_d;
    logic                        done_q, done_d;
    logic                        hs;
    logic                        last_slot;

    assign s_axis_tready = (state_q == S_FILL);
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign last_slot     = (cnt_q == LAST_SLOT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        bound_d = bound_q;
        tl_d    = tl_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = bram_start_index;
                    bound_d = bram_bound_index;
                    cnt_d   = '0;
                    buf_d   = '0;
                    tl_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (hs) begin
                    buf_d[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                    cnt_d = cnt_q + 1'b1;
                    if (last_slot || s_axis_tlast) begin
                        state_d = S_WRITE;
                        tl_d    = s_axis_tlast;
                        // Partial line, packet ending short of bound, or region full before tlast.
                        if (s_axis_tlast && (!last_slot || idx_q != bound_q))
                            err_d = 1'b1;
                        if (!s_axis_tlast && idx_q == bound_q)
                            err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                buf_d = '0;
                cnt_d = '0;
                if (tl_q || idx_q == bound_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FILL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        en_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            bound_q <= '0;
            tl_q    <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            bound_q <= bound_d;
            tl_q    <= tl_d;
            err_q   <= err_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign bram_en        = en_q;
    assign bram_wen       = en_q;
    assign bram_index     = idx_q;
    assign bram_wdata     = buf_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign tlast_mismatch = err_q;
endmodule

// File: tb/tb_axis_bram_line_packer.sv
// Randomized bench for axis_bram_line_packer against a word-list reference model.
module tb_axis_bram_line_packer;
    localparam int DW  = 8;
    localparam int WPL = 4;
    localparam int AW  = 12;
    localparam int LW  = DW * WPL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] sidx, bidx;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast;
    logic          tready, bram_en, bram_wen, busy, done, tlast_mismatch;
    logic [AW-1:0] bram_index;
    logic [LW-1:0] bram_wdata;

    axis_bram_line_packer #(.DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .BRAM_ADDR_LENGTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .bram_start_index(sidx), .bram_bound_index(bidx),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready), .bram_en(bram_en), .bram_wen(bram_wen),
        .bram_index(bram_index), .bram_wdata(bram_wdata),
        .busy(busy), .done(done), .tlast_mismatch(tlast_mismatch)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [DW-1:0] in_w[$];
    bit            in_l[$];
    logic [AW-1:0] exp_a[$], obs_a[$];
    logic [LW-1:0] exp_d[$], obs_d[$];
    bit            exp_err, obs_err, clr_after_start, timeout;
    int            exp_acc, obs_acc, obs_done, proto_bad, done_lag;

    // Reference: walk the word list, cut a line every WPL words or at tlast.
    task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] b);
        logic [AW-1:0] a;
        logic [LW-1:0] line;
        int pos;
        a = s; line = '0; pos = 0;
        exp_a.delete(); exp_d.delete(); exp_err = 0; exp_acc = 0;
        for (int i = 0; i < in_w.size(); i++) begin
            line[pos*DW +: DW] = in_w[i];
            pos++; exp_acc++;
            if (in_l[i] || pos == WPL) begin
                exp_a.push_back(a); exp_d.push_back(line);
                if (in_l[i]) begin exp_err = (pos != WPL) || (a != b); return; end
                if (a == b)  begin exp_err = 1; return; end
                a = a + 1'b1; line = '0; pos = 0;
            end
        end
    endtask

    task automatic run_transfer(input logic [AW-1:0] s, input logic [AW-1:0] b,
                                input int gap_mode, input bit busy_start);
        int wi, cyc, last_wr, done_at;
        bit prev_en, v;
        wi = 0; cyc = 0; last_wr = -100; done_at = -1; prev_en = 0;
        obs_a.delete(); obs_d.delete(); obs_err = 0; obs_done = 0; proto_bad = 0;
        @(negedge clk);
        start = 1; sidx = s; bidx = b;
        @(negedge clk);
        start = 0; sidx = AW'($urandom); bidx = AW'($urandom);
        clr_after_start = tlast_mismatch;
        while (cyc < 400) begin
            if (bram_en) begin
                obs_a.push_back(bram_index); obs_d.push_back(bram_wdata);
                if (!bram_wen || prev_en || tready) proto_bad++;
                last_wr = cyc;
            end
            if (bram_wen && !bram_en) proto_bad++;
            if (tready && !busy) proto_bad++;
            if (done) begin
                obs_done++;
                if (tready) proto_bad++;
                if (done_at < 0) begin done_at = cyc; obs_err = tlast_mismatch; end
            end
            prev_en = bram_en;
            if (done_at >= 0 && cyc >= done_at + 3) break;
            if (busy_start && cyc == 3) begin start = 1; sidx = 12'h007; bidx = 12'h009; end
            else start = 0;
            case (gap_mode)
                0:       v = 1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            tvalid = v && (wi < in_w.size());
            tdata  = tvalid ? in_w[wi] : DW'($urandom);
            tlast  = tvalid ? in_l[wi] : 1'($urandom);
            #1;
            if (tvalid && tready) wi++;
            @(negedge clk);
            cyc++;
        end
        tvalid = 0; tlast = 0; start = 0;
        timeout  = (done_at < 0);
        obs_acc  = wi;
        done_lag = done_at - last_wr;
    endtask

    task automatic test_transfer(input string name, input logic [AW-1:0] s, input logic [AW-1:0] b,
                                 input int gap_mode, input bit busy_start);
        model(s, b);
        run_transfer(s, b, gap_mode, busy_start);
        chk_cnt++;
        if (timeout || obs_a.size() != exp_a.size())
            $display("FAIL %s write_count got %0d want %0d timeout=%0d", name, obs_a.size(), exp_a.size(), timeout);
        else pass_cnt++;
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            chk_cnt++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i])
                $display("FAIL %s write%0d got @%h %h want @%h %h", name, i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_err !== exp_err || clr_after_start !== 1'b0)
            $display("FAIL %s mismatch got %0d (after start %0d) want %0d", name, obs_err, clr_after_start, exp_err);
        else pass_cnt++;
        chk_cnt++;
        if (obs_acc != exp_acc)
            $display("FAIL %s accepted got %0d want %0d", name, obs_acc, exp_acc);
        else pass_cnt++;
        chk_cnt++;
        if (obs_done != 1 || done_lag != 1 || proto_bad != 0)
            $display("FAIL %s done/protocol got done=%0d lag=%0d bad=%0d want 1 1 0", name, obs_done, done_lag, proto_bad);
        else pass_cnt++;
    endtask

    task automatic load_words(input logic [DW-1:0] base, input int n, input int last_at);
        in_w.delete(); in_l.delete();
        for (int i = 0; i < n; i++) begin
            in_w.push_back(base + DW'(i));
            in_l.push_back(i == last_at);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; tvalid = 0; tlast = 0; tdata = '0; sidx = '0; bidx = '0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({bram_en, bram_wen, bram_index, bram_wdata, busy, done, tlast_mismatch, tready} !== '0)
            $display("FAIL reset_outputs got en=%b idx=%h wd=%h busy=%b done=%b err=%b rdy=%b want all 0",
                     bram_en, bram_index, bram_wdata, busy, done, tlast_mismatch, tready);
        else pass_cnt++;
        rst = 0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, tready, bram_en} !== 3'b000)
            $display("FAIL idle_after_reset got busy=%b rdy=%b en=%b want 0", busy, tready, bram_en);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        load_words(8'h01, 8, 7);
        test_transfer("back_to_back", 12'd5, 12'd6, 0, 0);
        chk_cnt++;
        if (obs_d.size() != 2 || obs_d[0] !== 32'h04030201 || obs_d[1] !== 32'h08070605)
            $display("FAIL back_to_back_literal got %0d writes want 04030201,08070605", obs_d.size());
        else pass_cnt++;
    endtask

    task automatic test_valid_toggle();
        load_words(8'h01, 8, 7);
        test_transfer("valid_toggle", 12'd5, 12'd6, 1, 0);
    endtask

    task automatic test_partial_line();
        load_words(8'hA1, 6, 5);
        test_transfer("partial_line", 12'd2, 12'd3, 0, 0);
        chk_cnt++;
        if (obs_d.size() != 2 || obs_d[1] !== 32'h0000A6A5 || obs_err !== 1'b1)
            $display("FAIL partial_literal got %0d writes err=%0d want 0000A6A5 err=1", obs_d.size(), obs_err);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        load_words(8'h11, 8, 7);
        test_transfer("wrap", 12'hFFF, 12'h000, 2, 0);
        chk_cnt++;
        if (obs_a.size() != 2 || obs_a[0] !== 12'hFFF || obs_a[1] !== 12'h000)
            $display("FAIL wrap_literal got %0d writes want @FFF then @000", obs_a.size());
        else pass_cnt++;
    endtask

    task automatic test_overlong();
        load_words(8'h31, 8, -1);
        test_transfer("overlong", 12'd1, 12'd1, 0, 1);
    endtask

    task automatic test_mid_reset();
        int seen;
        @(negedge clk);
        start = 1; sidx = 12'd5; bidx = 12'd6;
        @(negedge clk);
        start = 0; tvalid = 1; tlast = 0; tdata = 8'h55;
        @(negedge clk);
        tdata = 8'h66;
        @(negedge clk);
        tvalid = 0;
        #2 rst = 1;
        #1;
        chk_cnt++;
        if ({bram_en, bram_wen, bram_index, bram_wdata, busy, done, tlast_mismatch, tready} !== '0)
            $display("FAIL mid_reset_outputs got en=%b idx=%h wd=%h busy=%b done=%b want all 0",
                     bram_en, bram_index, bram_wdata, busy, done);
        else pass_cnt++;
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bram_en || done || busy) seen++;
        end
        chk_cnt++;
        if (seen != 0) $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen);
        else pass_cnt++;
        load_words(8'h01, 8, 7);
        test_transfer("after_reset", 12'd5, 12'd6, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            logic [AW-1:0] s, b;
            int len, n, use_tl;
            s = AW'($urandom);
            if (t < 3) s = 12'hFFE + AW'(t);
            len = $urandom_range(1, 3);
            b = s + AW'(len - 1);
            use_tl = ($urandom_range(0, 3) != 0);
            n = use_tl ? $urandom_range(1, len * WPL + 2) : len * WPL + $urandom_range(0, 3);
            in_w.delete(); in_l.delete();
            for (int i = 0; i < n; i++) begin
                in_w.push_back(DW'($urandom));
                in_l.push_back(use_tl && i == n - 1);
            end
            test_transfer($sformatf("random%0d", t), s, b, 2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_partial_line();
        test_wrap();
        test_overlong();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
